// File: rtl/serial_add_controller_pkg.sv
// rtl/serial_add_controller_pkg.sv - shared encodings for the serial add controller
//
// Purpose: controller FSM state encoding and the serial adder's state encoding.
// Ports:   none (package).

package serial_add_controller_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_CLEAR = CLEAR,
        ST_SHIFT = SHIFT,
        ST_DRAIN = DRAIN,
        ST_DONE  = DONE
    } state_t;

    // Serial adder state is {carry, sum_bit}: F = state[0], Cout = state[1].
    localparam logic [1:0] ADD_S0 = 2'd0;
    localparam logic [1:0] ADD_S1 = 2'd1;
    localparam logic [1:0] ADD_S2 = 2'd2;
    localparam logic [1:0] ADD_S3 = 2'd3;

endpackage

// File: rtl/serial_add_controller_if.sv
// rtl/serial_add_controller_if.sv - host-side handshake bundle of the serial add controller
//
// Purpose: groups the parallel operand/result handshake.
// Signals: start, a_in, b_in (host -> controller); busy, done, sum, cout (controller -> host).
// Modports: master = host side, slave = controller side.

interface serial_add_controller_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a_in, b_in,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_controller_shift_reg_lsb.sv
// rtl/serial_add_controller_shift_reg_lsb.sv - loadable right-shift register, serial-in at MSB
//
// Purpose: WIDTH-bit register; load has priority over shift; shift moves toward the LSB.
// Ports:   clk, rst (async, active-high), load, load_val, shift, ser_in, q.

module shift_reg_lsb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_val;
        end else if (shift) begin
            data_d = {ser_in, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/serial_add_controller.sv
// rtl/serial_add_controller.sv - parallel front end for a bit-serial Moore adder
//
// Purpose: captures two operands on start, clears the adder, streams operand bits
//          LSB first, and gathers the registered serial sum into a parallel word.
// Ports:   clk, rst (async, active-high)
//          host      : start/a_in/b_in in, busy/done/sum/cout out (slave modport)
//          ser_a/ser_b : serial operand bits to the adder
//          adder_clr : synchronous clear to the adder
//          ser_f/ser_cout : registered sum bit and carry state from the adder

module serial_add_controller
    import serial_add_controller_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_controller_if.slave host,
    output logic                  ser_a,
    output logic                  ser_b,
    output logic                  adder_clr,
    input  logic                  ser_f,
    input  logic                  ser_cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             load_ops;
    logic             shift_ops;
    logic             shift_cap;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] cap_q;
    logic             unused_sh;

    shift_reg_lsb #(.WIDTH(WIDTH)) u_sh_a (
        .clk      (clk),
        .rst      (rst),
        .load     (load_ops),
        .load_val (host.a_in),
        .shift    (shift_ops),
        .ser_in   (1'b0),
        .q        (a_sh)
    );

    shift_reg_lsb #(.WIDTH(WIDTH)) u_sh_b (
        .clk      (clk),
        .rst      (rst),
        .load     (load_ops),
        .load_val (host.b_in),
        .shift    (shift_ops),
        .ser_in   (1'b0),
        .q        (b_sh)
    );

    shift_reg_lsb #(.WIDTH(WIDTH)) u_sh_cap (
        .clk      (clk),
        .rst      (rst),
        .load     (load_ops),
        .load_val ({WIDTH{1'b0}}),
        .shift    (shift_cap),
        .ser_in   (ser_f),
        .q        (cap_q)
    );

    // Operand upper bits only leave through shifting; the capture LSB is
    // discarded by the final shift that forms the result.
    assign unused_sh = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1], cap_q[0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        load_ops  = 1'b0;
        shift_ops = 1'b0;
        shift_cap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    load_ops = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_ops = 1'b1;
                // The adder output lags by one cycle, so nothing valid to capture at cnt 0.
                shift_cap = (cnt_q != '0);
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                shift_cap = 1'b1;
                sum_d     = {ser_f, cap_q[WIDTH-1:1]};
                cout_d    = ser_cout;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // rst feeds the clear directly so the adder is held in S0 while reset is asserted.
    assign adder_clr = rst | (state_q == ST_CLEAR);
    assign ser_a     = (state_q == ST_SHIFT) & a_sh[0];
    assign ser_b     = (state_q == ST_SHIFT) & b_sh[0];
    assign host.busy = (state_q == ST_CLEAR) | (state_q == ST_SHIFT) | (state_q == ST_DRAIN);
    assign host.done = (state_q == ST_DONE);
    assign host.sum  = sum_q;
    assign host.cout = cout_q;

endmodule
